// File: rtl/uart_receiver.sv
// 8N1 UART receive path: two-flop synchronizer, start-bit validation at mid-bit,
// LSB-first data sampling and stop-bit check, with a one-cycle valid pulse per good byte.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       framing_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    shift_r;
    logic          rx_s1_r;
    logic          rx_sync_r;

    // Synchronizer, frame FSM and registered outputs in one clocked process.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            rx_s1_r     <= 1'b1;
            rx_sync_r   <= 1'b1;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_busy     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rx_s1_r   <= rx;
            rx_sync_r <= rx_s1_r;
            rx_valid  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rx_sync_r) begin
                        state_r <= START;
                        cnt_r   <= CNT_ZERO;
                        rx_busy <= 1'b1;
                    end else begin
                        rx_busy <= 1'b0;
                    end
                end
                START: begin
                    // A start bit still low at mid-bit is genuine; otherwise it was a glitch.
                    if (cnt_r == HALF_LAST) begin
                        if (!rx_sync_r) begin
                            state_r <= DATA;
                            cnt_r   <= CNT_ZERO;
                            idx_r   <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        shift_r[idx_r] <= rx_sync_r;
                        cnt_r          <= CNT_ZERO;
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        rx_busy <= 1'b0;
                        if (rx_sync_r) begin
                            rx_data     <= shift_r;
                            rx_valid    <= 1'b1;
                            framing_err <= 1'b0;
                            state_r     <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state_r     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new frame can start.
                    if (rx_sync_r) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    idx_r   <= 3'd0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the serial driver pushes the expected byte and
// arrival cycle of every well-framed byte; a monitor pops and compares on rx_valid.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       framing_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    logic [7:0] last_good;
    logic       exp_ferr;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .framing_err (framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One serial bit: change the line on a falling edge and hold it for CPB cycles.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    // Full 8N1 frame; a good stop bit means the byte must appear 154 cycles after
    // the first clock edge that samples the start bit low.
    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        int k;
        @(negedge clk);
        rx = 1'b0;
        k  = cyc + 1;
        if (stop_ok) begin
            exp_data.push_back(data);
            exp_cyc.push_back(k + 2 + HALF + 9 * CPB);
            last_good = data;
            exp_ferr  = 1'b0;
        end else begin
            exp_ferr = 1'b1;
        end
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_ok);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid === 1'b1) begin
                check("valid_expected", {31'd0, exp_data.size() > 0}, 32'd1);
                check("ferr_clear_on_valid", {31'd0, framing_err}, 32'd0);
                if (exp_data.size() > 0) begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_data.pop_front()});
                    check("valid_cycle", cyc, exp_cyc.pop_front());
                end
            end
        end
    end

    initial begin
        int busy_cycles;
        int gap;
        logic prev_ok;
        logic ok;
        logic [7:0] c3;
        reset     = 1'b0;
        rx        = 1'b1;
        last_good = 8'h00;
        exp_ferr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {24'd0, rx_data}, 32'd0);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_ferr", {31'd0, framing_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(5);

        send_frame(8'hAA, 1'b1);
        idle(4);
        check("single_ferr", {31'd0, framing_err}, 32'd0);
        check("single_data", {24'd0, rx_data}, 32'hAA);

        send_frame(8'h55, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(6);
        check("b2b_last_data", {24'd0, rx_data}, 32'hFF);

        // Glitch: line low for 5 clock edges; busy spans START for exactly HALF cycles.
        busy_cycles = 0;
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rx_busy) busy_cycles++;
            if (i == 4) rx = 1'b1;
        end
        check("glitch_busy_cycles", busy_cycles, HALF);
        check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        check("glitch_data_kept", {24'd0, rx_data}, {24'd0, last_good});

        send_frame(8'h3C, 1'b0);
        check("ferr_set", {31'd0, framing_err}, 32'd1);
        check("ferr_data_kept", {24'd0, rx_data}, {24'd0, last_good});
        idle(5);
        send_frame(8'h81, 1'b1);
        idle(3);
        check("ferr_cleared", {31'd0, framing_err}, 32'd0);
        check("after_ferr_data", {24'd0, rx_data}, 32'h81);

        @(negedge clk);
        rx = 1'b0;
        repeat (400) @(negedge clk);
        check("break_ferr", {31'd0, framing_err}, 32'd1);
        check("break_data_kept", {24'd0, rx_data}, 32'h81);
        idle(10);
        send_frame(8'h12, 1'b1);
        idle(3);
        check("after_break_data", {24'd0, rx_data}, 32'h12);
        check("after_break_ferr", {31'd0, framing_err}, 32'd0);

        // Randomized frames with occasional bad stop bits and random idle gaps.
        prev_ok = 1'b1;
        for (int n = 0; n < 24; n++) begin
            gap = $urandom_range(0, 6);
            if (!prev_ok && gap < 2) gap = 2;
            if (gap > 0) idle(gap);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(8'($urandom_range(0, 255)), ok);
            check("rand_ferr", {31'd0, framing_err}, {31'd0, exp_ferr});
            check("rand_data", {24'd0, rx_data}, {24'd0, last_good});
            prev_ok = ok;
        end
        idle(5);

        // Reset in the middle of the data bits of 0xC3.
        c3 = 8'hC3;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_bit(c3[i]);
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_data", {24'd0, rx_data}, 32'd0);
        check("midreset_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_busy", {31'd0, rx_busy}, 32'd0);
        check("midreset_ferr", {31'd0, framing_err}, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        last_good = 8'h00;
        exp_ferr  = 1'b0;
        idle(20);
        check("post_reset_idle_busy", {31'd0, rx_busy}, 32'd0);
        send_frame(8'hC3, 1'b1);
        idle(5);
        check("post_reset_data", {24'd0, rx_data}, 32'hC3);

        idle(20);
        check("scoreboard_drained", exp_data.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the UART link: the receiving end of the 8N1 serial stream that the `Uart_protocol` transmitter drives. It synchronizes the asynchronous `rx` line, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each good byte is presented on a parallel port with a one-cycle valid pulse. It sits between the board pin and downstream byte consumers, in the same clock domain as the transmitter.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200 baud), gives the clock cycles per serial bit. Legal range is at least 4 and must match the transmitter's setting. `HALF = CLKS_PER_BIT/2` (integer division).
- `clk` input, 1 bit: system clock, rising-edge.
- `reset` input, 1 bit: reset, synchronous, active-low.
- `rx` input, 1 bit: serial line, asynchronous to `clk`, idles high.
- `rx_data` output, 8 bits: last correctly framed byte; held until the next good frame.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` is updated.
- `rx_busy` output, 1 bit: high while a frame is being received (states START, DATA, STOP).
- `framing_err` output, 1 bit: set when a sampled stop bit is 0; cleared by the next good frame or by reset.

## Operation
- Synchronizer: a two-flop chain `rx` to `rx_s1` to `rx_sync`. Both flops reset to 1. All decisions use `rx_sync` only.
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide. The bit index is 3 bits. The shift register is 8 bits.
- FSM states are IDLE, START, DATA, STOP and WAIT_IDLE.
- IDLE: if `rx_sync`==0, go to START with counter=0.
- START: count up. When counter==HALF-1, sample `rx_sync`:
  - 0: go to DATA with counter=0 and index=0.
  - 1: glitch; return to IDLE with no output change.
- DATA: count up. When counter==CLKS_PER_BIT-1:
  - Shift `rx_sync` into bit[index] (LSB first) and set counter=0.
  - If index==7, go to STOP; otherwise index+1.
- STOP: when counter==CLKS_PER_BIT-1, sample `rx_sync`:
  - 1: `rx_data` gets the shift register, `rx_valid`=1 for one cycle, `framing_err`=0, go to IDLE.
  - 0: `framing_err`=1, `rx_data` unchanged, no `rx_valid`, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_sync`==1, then go to IDLE. A held-low line (break) never produces spurious frames.
- Reset (`reset`==0 at a clock edge), from any state including mid-frame:
  - FSM goes to IDLE; counter and index are cleared.
  - `rx_data`=8'h00, `rx_valid`=0, `rx_busy`=0, `framing_err`=0.
  - The partial frame is discarded.
- A line that is low when reset is released is treated as a start edge.
- Back-to-back frames: after a good stop sample the FSM is in IDLE on the next cycle. It can accept a start bit that immediately follows the stop bit with no extra idle time.

## Timing
- Let k be the first rising edge at which `rx` is sampled low. `rx_sync` is low after edge k+1, and START is entered at edge k+2.
- Start bit is validated at edge k+2+HALF.
- Data bit i (0..7) is sampled at edge k+2+HALF+(i+1)·CLKS_PER_BIT.
- Stop bit is sampled at edge E = k+2+HALF+9·CLKS_PER_BIT. `rx_valid` is high during the cycle after E, and `rx_data` is valid from that same cycle.
- With CLKS_PER_BIT=16: E = k+154.
- `rx_busy` rises after edge k+2 and falls after edge E.
- `rx_valid` is never high for more than one consecutive cycle, and is never high in the same cycle that `framing_err` is set.
- Glitch rejection: any low pulse on `rx_sync` shorter than HALF cycles returns the FSM to IDLE with no output change.

## Test plan
(All scenarios use CLKS_PER_BIT=16, 10 ns clock.)
- **Single frame:** send 8'hAA as start, 0,1,0,1,0,1,0,1 (LSB first), stop. Required: `rx_data`=8'hAA, one `rx_valid` pulse exactly 154 cycles after the first low sample, `framing_err`=0.
- **Back-to-back frames:** send 8'h55, 8'h00, 8'hFF with no idle gap. Required: three `rx_valid` pulses 160 cycles apart, data 55/00/FF in order.
- **Glitch rejection:** hold `rx` low for 5 cycles, then high. Required: `rx_busy` pulses, no `rx_valid`, `rx_data` unchanged, FSM back in IDLE.
- **Framing error:** send a frame of 8'h3C with stop bit 0, then return high, then send a good 8'h81. Required:
  - No valid on the bad frame; `framing_err`=1 and `rx_data` unchanged.
  - After the good frame: `rx_valid` pulse, `rx_data`=8'h81, `framing_err`=0.
- **Break condition:** hold `rx` low for 400 cycles, then high, then send 8'h12. Required: `framing_err`=1 and no valid during the break; exactly one valid afterwards with 8'h12.
- **Reset mid-frame:** assert `reset`=0 for 1 cycle during DATA of a frame of 8'hC3. Required: all outputs at reset values next cycle, no valid for the aborted frame, and the next full frame is received correctly.
